store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Write-side counterpart of the MEM/WB load path: aligns RV32 SB/SH/SW store data to word lanes,
//  generates byte enables, and queues stores in a small FIFO. The FIFO drains to the data memory
//  over a req/ack handshake. Sits between the MEM stage and DM.
//  Flags loads that hit a pending word so the hazard unit can stall.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of 2, >=2
//  AW      32  address width
// PORTS
//  clk         in   1      clock; all state on posedge
//  rst_n       in   1      reset, asynchronous, active-low
//  st_valid    in   1      store request from MEM stage
//  st_size     in   2      funct3[1:0]: 00 SB, 01 SH, 10 SW, 11 reserved
//  st_addr     in   AW     byte address
//  st_data     in   32     rs2 value, unaligned (LSB-justified)
//  st_ready    out  1      buffer can accept; = (count < DEPTH)
//  ld_check    in   1      a load is in MEM stage
//  ld_addr     in   AW     load byte address
//  ld_hazard   out  1      ld_check && any valid entry with addr[AW-1:2] == ld_addr[AW-1:2]
//  dm_req      out  1      write request to DM
//  dm_ack      in   1      DM accepted the head write
//  dm_addr     out  AW     word-aligned address (bits [1:0] = 0)
//  dm_wdata    out  32     lane-aligned data
//  dm_be       out  4      byte enables, active-high; bit i = byte lane i
//  count       out  $clog2(DEPTH+1)  valid entries, including the one in flight
//  empty       out  1      count == 0
// BEHAVIOUR
//  Reset (async, any cycle, including mid-handshake):
//   - all entries invalidated; pointers and count = 0.
//   - dm_req = 0 and dm_addr/dm_wdata/dm_be = 0 immediately.
//   - state = IDLE; st_ready = 1; empty = 1.
//  Enqueue: when st_valid && st_ready && st_size != 11, write the aligned entry at the tail on the clock edge.
//   - SB: wdata = {4{d[7:0]}},  be = 4'b0001 << addr[1:0]
//   - SH: wdata = {2{d[15:0]}}, be = addr[1] ? 4'b1100 : 4'b0011
//   - SW: wdata = d,            be = 4'b1111
//   - st_size 11: dropped; nothing is enqueued.
//  Drain FSM (states IDLE, REQ):
//   - IDLE: if count != 0, load the dm_* registers from the head and go to REQ; dm_req = 1 the next cycle.
//   - REQ: hold dm_req/dm_addr/dm_wdata/dm_be stable until dm_ack.
//   - REQ on dm_ack: pop the head.
//       - entries remain: load the next head, stay in REQ (back-to-back, no bubble).
//       - none remain: go to IDLE, dm_req = 0; dm_* hold their last values.
//  Latency: a store accepted at edge N into an empty buffer gives dm_req = 1 after edge N+1.
//  Simultaneous enqueue and pop: both happen; count unchanged; the new entry is queued behind the head.
//  Full: st_ready = 0 even if dm_ack arrives that cycle (no pass-through); it rises the cycle after the pop.
//  Pointers wrap modulo DEPTH; count never exceeds DEPTH.
//  ld_hazard is combinational over the registered entries, including the head in flight.
//  An entry being enqueued in the same cycle is not checked.
//  Program order to DM is strictly FIFO.
// CONFIGURATION
//  STORE_MISALIGN_CHK_EN defined:
//   - a SH with addr[0] = 1, or a SW with addr[1:0] != 0, is not enqueued.
//   - output misalign_err (1b) pulses high for 1 cycle after the offending st_valid edge.
//   - misalign_err resets to 0.
//  STORE_MISALIGN_CHK_EN undefined:
//   - no misalign_err port.
//   - SH uses addr[1] only; SW ignores addr[1:0]; every non-reserved store is enqueued.
// TESTING
//  - SB addr 0x103, data 0xAB, dm_ack tied 1 -> dm_req after 1 cycle; dm_addr 0x100,
//    dm_wdata 0xABABABAB, dm_be 1000.
//  - SH 0x202 data 0x1234, then SW 0x300 data 0xDEADBEEF, back-to-back, ack every cycle ->
//    be 1100/wdata 0x12341234, then be 1111/0xDEADBEEF in consecutive cycles; empty = 1 after.
//  - DEPTH+1 stores with dm_ack = 0 -> st_ready drops at count = 4; the 5th is not accepted.
//    Then ack once -> st_ready = 1 one cycle after the pop.
//  - Store 0x400 pending, ld_check = 1 with ld_addr 0x402 -> ld_hazard = 1;
//    ld_addr 0x404 -> 0; after drain -> 0.
//  - rst_n low while in REQ with 3 entries -> dm_req = 0 asynchronously, count = 0, st_ready = 1;
//    no write after release.
//  - With STORE_MISALIGN_CHK_EN: SW 0x501 -> misalign_err = 1 for one cycle, count stays 0.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: aligns RV32 SB/SH/SW data to word lanes and queues stores for a req/ack drain to DM.
// Optional STORE_MISALIGN_CHK_EN drops misaligned SH/SW and pulses misalign_err.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  input  logic [1:0]                   st_size,
  input  logic [AW-1:0]                st_addr,
  input  logic [31:0]                  st_data,
  output logic                         st_ready,
  input  logic                         ld_check,
  input  logic [AW-1:0]                ld_addr,
  output logic                         ld_hazard,
  output logic                         dm_req,
  input  logic                         dm_ack,
  output logic [AW-1:0]                dm_addr,
  output logic [31:0]                  dm_wdata,
  output logic [3:0]                   dm_be,
  output logic [$clog2(DEPTH+1)-1:0]   count,
`ifdef STORE_MISALIGN_CHK_EN
  output logic                         empty,
  output logic                         misalign_err
`else
  output logic                         empty
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic {IDLE, REQ} state_e;
  state_e            state_q, state_d;
  logic [PW-1:0]     head_q, tail_q, head_nxt, off;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-3:0]     mem_addr_q [DEPTH];
  logic [31:0]       mem_data_q [DEPTH];
  logic [3:0]        mem_be_q   [DEPTH];
  logic [AW-3:0]     dm_waddr_q, dm_waddr_d;
  logic [31:0]       dm_wdata_q, dm_wdata_d, in_wdata;
  logic [3:0]        dm_be_q, dm_be_d, in_be;
  logic              mis, push, pop, hit;
  assign in_wdata = st_size == 2'b00 ? {4{st_data[7:0]}} :
                    st_size == 2'b01 ? {2{st_data[15:0]}} : st_data;
  assign in_be    = st_size == 2'b00 ? 4'b0001 << st_addr[1:0] :
                    st_size == 2'b01 ? (st_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef STORE_MISALIGN_CHK_EN
  assign mis = (st_size == 2'b01 && st_addr[0]) || (st_size == 2'b10 && st_addr[1:0] != 2'b00);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign_err <= 1'b0;
    else        misalign_err <= st_valid && mis;
`else
  assign mis = 1'b0;
`endif
  assign st_ready  = cnt_q < CW'(DEPTH);
  assign push      = st_valid && st_ready && st_size != 2'b11 && !mis;
  assign pop       = state_q == REQ && dm_ack;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign head_nxt  = head_q + PW'(1);
  assign count     = cnt_q;
  assign empty     = cnt_q == '0;
  assign dm_req    = state_q == REQ;
  assign dm_addr   = {dm_waddr_q, 2'b00};
  assign dm_wdata  = dm_wdata_q;
  assign dm_be     = dm_be_q;
  assign ld_hazard = ld_check && hit;
  // On a pop that leaves only the entry being enqueued, it is forwarded straight to DM.
  always_comb begin
    state_d    = state_q;
    dm_waddr_d = dm_waddr_q;
    dm_wdata_d = dm_wdata_q;
    dm_be_d    = dm_be_q;
    if (state_q == IDLE && cnt_q != '0) begin
      state_d    = REQ;
      dm_waddr_d = mem_addr_q[head_q];
      dm_wdata_d = mem_data_q[head_q];
      dm_be_d    = mem_be_q[head_q];
    end else if (pop) begin
      state_d    = cnt_d == '0 ? IDLE : REQ;
      dm_waddr_d = cnt_d == '0 ? dm_waddr_q : cnt_q > CW'(1) ? mem_addr_q[head_nxt] : st_addr[AW-1:2];
      dm_wdata_d = cnt_d == '0 ? dm_wdata_q : cnt_q > CW'(1) ? mem_data_q[head_nxt] : in_wdata;
      dm_be_d    = cnt_d == '0 ? dm_be_q    : cnt_q > CW'(1) ? mem_be_q[head_nxt]   : in_be;
    end
  end
  always_comb begin
    hit = 1'b0;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - head_q;
      if ({1'b0, off} < cnt_q && mem_addr_q[i] == ld_addr[AW-1:2]) hit = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      dm_waddr_q <= '0;
      dm_wdata_q <= '0;
      dm_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= pop ? head_nxt : head_q;
      tail_q     <= push ? tail_q + PW'(1) : tail_q;
      cnt_q      <= cnt_d;
      dm_waddr_q <= dm_waddr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_be_q    <= dm_be_d;
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_addr_q[tail_q] <= st_addr[AW-1:2];
      mem_data_q[tail_q] <= in_wdata;
      mem_be_q[tail_q]   <= in_be;
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: queue-based reference model plus decoupled DM-side scoreboard monitor.
module tb_store_buffer;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        st_valid = 1'b0, ld_check = 1'b0, dm_ack = 1'b0;
  logic [1:0]  st_size = 2'b00;
  logic [31:0] st_addr = '0, st_data = '0, ld_addr = '0;
  logic        st_ready, ld_hazard, dm_req, empty;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic [2:0]  count;
`ifdef STORE_MISALIGN_CHK_EN
  logic        misalign_err;
`endif
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [1:0] size;} st_t;
  st_t  mq[$];
  st_t  sbq[$];
  int   checks = 0, failures = 0;
  logic req_m = 1'b0, mis_m = 1'b0;

  store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_size(st_size), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready), .ld_check(ld_check), .ld_addr(ld_addr),
    .ld_hazard(ld_hazard), .dm_req(dm_req), .dm_ack(dm_ack), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be), .count(count),
`ifdef STORE_MISALIGN_CHK_EN
    .empty(empty), .misalign_err(misalign_err)
`else
    .empty(empty)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_be(st_t s);
    int n = 1 << s.size;
    int base = int'(s.addr[1:0]) & ~(n - 1);
    logic [3:0] be = '0;
    for (int k = 0; k < 4; k++) be[k] = (k >= base) && (k < base + n);
    return be;
  endfunction

  function automatic logic [31:0] exp_wd(st_t s);
    int n = 1 << s.size;
    logic [31:0] w = '0;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = s.data[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic mis_of(logic [1:0] sz, logic [31:0] a);
`ifdef STORE_MISALIGN_CHK_EN
    return (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (rst_n && dm_req) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dm_req_unexpected actual=1 required=0 at %0t", $time);
      end else begin
        chk("dm_addr", dm_addr, {sbq[0].addr[31:2], 2'b00});
        chk("dm_wdata", dm_wdata, exp_wd(sbq[0]));
        chk("dm_be", {28'h0, dm_be}, {28'h0, exp_be(sbq[0])});
        if (dm_ack) void'(sbq.pop_front());
      end
    end

  task automatic cyc(input logic v, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                     input logic ack, input logic ldc, input logic [31:0] lda);
    int   sz0;
    logic pop, push, hz;
    st_t  e;
    st_valid = v; st_size = sz; st_addr = a; st_data = d;
    dm_ack = ack; ld_check = ldc; ld_addr = lda;
    @(negedge clk);
    chk("count", {29'h0, count}, mq.size());
    chk("st_ready", {31'h0, st_ready}, {31'h0, mq.size() < DEPTH});
    chk("empty", {31'h0, empty}, {31'h0, mq.size() == 0});
    chk("dm_req", {31'h0, dm_req}, {31'h0, req_m});
    hz = 1'b0;
    foreach (mq[i]) if (mq[i].addr[31:2] == lda[31:2]) hz = ldc;
    chk("ld_hazard", {31'h0, ld_hazard}, {31'h0, hz});
`ifdef STORE_MISALIGN_CHK_EN
    chk("misalign_err", {31'h0, misalign_err}, {31'h0, mis_m});
`endif
    @(posedge clk);
    sz0  = mq.size();
    pop  = req_m && ack;
    push = v && sz0 < DEPTH && sz != 2'b11 && !mis_of(sz, a);
    e.addr = a; e.data = d; e.size = sz;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back(e);
      sbq.push_back(e);
    end
    req_m = req_m ? (!pop || mq.size() != 0) : (sz0 != 0);
    mis_m = v && mis_of(sz, a);
    #1;
  endtask

  task automatic idle(input int n, input logic ack);
    repeat (n) cyc(1'b0, 2'b00, 32'h0, 32'h0, ack, 1'b0, 32'h0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_dm_req", {31'h0, dm_req}, 32'h0);
    chk("rst_count", {29'h0, count}, 32'h0);
    chk("rst_st_ready", {31'h0, st_ready}, 32'h1);
    chk("rst_empty", {31'h0, empty}, 32'h1);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    chk("rst_dm_be", {28'h0, dm_be}, 32'h0);
  endtask

  initial begin
    #3;
    check_reset_outputs();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    // single SB, ack tied high
    cyc(1'b1, 2'b00, 32'h103, 32'h000000AB, 1'b1, 1'b0, 32'h0);
    idle(3, 1'b1);
    // SH then SW back to back
    cyc(1'b1, 2'b01, 32'h202, 32'h00001234, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 2'b10, 32'h300, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0);
    idle(4, 1'b1);
    // fill past DEPTH with ack held low, then a single ack
    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 2'b10, 32'h600 + 32'(4 * i), $urandom, 1'b0, 1'b0, 32'h0);
    idle(2, 1'b0);
    cyc(1'b1, 2'b10, 32'h700, 32'h11111111, 1'b1, 1'b0, 32'h0);
    cyc(1'b1, 2'b10, 32'h704, 32'h22222222, 1'b0, 1'b0, 32'h0);
    idle(8, 1'b1);
    // load hazard against a pending word
    cyc(1'b1, 2'b10, 32'h400, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h402);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h404);
    repeat (4) cyc(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b1, 32'h402);
    // asynchronous reset with three entries, mid-handshake
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'b00, 32'h800 + 32'(i), $urandom, 1'b0, 1'b0, 32'h0);
    idle(2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    mq.delete(); sbq.delete(); req_m = 1'b0; mis_m = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    idle(4, 1'b1);
`ifdef STORE_MISALIGN_CHK_EN
    cyc(1'b1, 2'b10, 32'h501, 32'h12345678, 1'b1, 1'b0, 32'h0);
    idle(2, 1'b1);
`endif
    // randomized traffic over a small address window so hazards occur
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 32'($urandom_range(0, 63)));
    idle(20, 1'b1);
    chk("sb_drained", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
